// File: rtl/pc_sequencer_if.sv
// Bundle of every signal that pc_sequencer exchanges with the control/ALU
// decision logic and the instruction memory. The sequencer uses the master
// side, and the environment (control unit, memory, bench) uses the slave side.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  // Decision inputs coming from the control path
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_offset;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              stall;

  // Instruction-memory handshake
  logic              imem_ready;
  logic              imem_req;

  // Sequencer status
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              fault;
  logic [ADDR_W-1:0] fault_addr;
  logic [31:0]       fetch_count;

  modport master (
    input  branch_taken, branch_offset, jump, jump_target, stall, imem_ready,
    output pc, pc_plus4, imem_req, fault, fault_addr, fetch_count
  );

  modport slave (
    output branch_taken, branch_offset, jump, jump_target, stall, imem_ready,
    input  pc, pc_plus4, imem_req, fault, fault_addr, fetch_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage. It holds the fetch address and issues instruction
// memory requests. On every accepted fetch it loads the next PC, which is
// chosen in this order: jump, then taken branch, then sequential. A jump to a
// target that is not word aligned is trapped into a sticky FAULT state, and
// only reset can leave that state.
module pc_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] branch_target;
  logic              misaligned;
  logic              imem_req;
  logic              accept;

  // Address arithmetic. All adds wrap modulo 2^ADDR_W, and a taken branch
  // always lands on a word boundary because the offset is scaled by 4.
  always_comb begin
    pc_plus4      = pc_q + ADDR_W'(4);
    branch_target = pc_plus4 + (bus.branch_offset << 2);
    misaligned    = bus.jump_target[1:0] != 2'b00;
  end

  // Next-state and request logic. Decision inputs only matter on a cycle
  // where the memory accepts the request.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    fetch_count_d = fetch_count_q;
    imem_req      = 1'b0;
    accept        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // This is the bubble cycle after reset. No request is issued.
        state_d = FETCH;
      end

      FETCH: begin
        // stall wins over imem_ready and drops the request in the same cycle.
        imem_req = !bus.stall;
        accept   = imem_req && bus.imem_ready;
        if (accept) begin
          fetch_count_d = fetch_count_q + 32'd1;
          if (bus.jump) begin
            if (misaligned) begin
              // The request was still accepted, so the count advances, but
              // the PC keeps the last good address.
              state_d      = FAULT;
              fault_d      = 1'b1;
              fault_addr_d = bus.jump_target;
            end else begin
              pc_d = bus.jump_target;
            end
          end else if (bus.branch_taken) begin
            pc_d = branch_target;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      FAULT: begin
        // Frozen until reset, with no requests.
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. An asynchronous reset drops any
  // outstanding request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fetch_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples values from before the clock edge.
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.imem_req    = imem_req;
  assign bus.fault       = fault_q;
  assign bus.fault_addr  = fault_addr_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. It has three parts: a directed
// vector table, hand-written sequences for the fault, counter-wrap and
// asynchronous-reset corners, and random stimulus. A behavioural model
// predicts every result.
module tb_pc_sequencer;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  pc_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: has the bubble happened, is the block trapped, and
  // what are the architectural values.
  bit          m_started;
  bit          m_fault;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_faddr;

  typedef struct {
    logic        bt;
    logic [31:0] off;
    logic        j;
    logic [31:0] jt;
    logic        st;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic bt, logic [31:0] off, logic j, logic [31:0] jt,
                              logic st, logic rdy, logic exp_req, logic [31:0] exp_pc,
                              logic [31:0] exp_cnt, logic exp_fault);
    vec_t v;
    v.bt = bt; v.off = off; v.j = j; v.jt = jt; v.st = st; v.rdy = rdy;
    v.exp_req = exp_req; v.exp_pc = exp_pc; v.exp_cnt = exp_cnt; v.exp_fault = exp_fault;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_fault   = 1'b0;
    m_pc      = RESET_PC;
    m_cnt     = 32'd0;
    m_faddr   = 32'd0;
  endtask

  function automatic logic model_req(input logic st);
    return m_started && !m_fault && !st;
  endfunction

  // The model's view of one rising edge.
  task automatic model_clock(input logic bt, input logic [31:0] off, input logic j,
                             input logic [31:0] jt, input logic st, input logic rdy);
    if (!m_started) begin
      m_started = 1'b1;
    end else if (model_req(st) && rdy) begin
      m_cnt = m_cnt + 1;
      if (j) begin
        if (jt % 4 != 0) begin
          m_fault = 1'b1;
          m_faddr = jt;
        end else begin
          m_pc = jt;
        end
      end else if (bt) begin
        m_pc = m_pc + 4 + off * 4;
      end else begin
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic drive(input logic bt, input logic [31:0] off, input logic j,
                       input logic [31:0] jt, input logic st, input logic rdy);
    bus.branch_taken  = bt;
    bus.branch_offset = off;
    bus.jump          = j;
    bus.jump_target   = jt;
    bus.stall         = st;
    bus.imem_ready    = rdy;
  endtask

  // One clock cycle, entered just after a falling edge. The combinational
  // outputs are checked before the rising edge and the registered outputs
  // after it.
  task automatic run_cycle(input string tag, input logic bt, input logic [31:0] off,
                           input logic j, input logic [31:0] jt, input logic st,
                           input logic rdy, output logic req_seen);
    drive(bt, off, j, jt, st, rdy);
    #1;
    check({tag, ".imem_req"}, 32'(bus.imem_req), 32'(model_req(st)));
    check({tag, ".pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
    req_seen = bus.imem_req;
    @(posedge clk);
    model_clock(bt, off, j, jt, st, rdy);
    @(negedge clk);
    check({tag, ".pc"}, bus.pc, m_pc);
    check({tag, ".fetch_count"}, bus.fetch_count, m_cnt);
    check({tag, ".fault"}, 32'(bus.fault), 32'(m_fault));
    check({tag, ".fault_addr"}, bus.fault_addr, m_faddr);
  endtask

  // Reset is asserted 2 time units after a falling edge. The outputs are
  // checked before any rising edge, and reset is released on the next
  // falling edge.
  task automatic async_reset_pulse(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_pc"}, bus.pc, RESET_PC);
    check({tag, ".rst_req"}, 32'(bus.imem_req), 32'd0);
    check({tag, ".rst_fault"}, 32'(bus.fault), 32'd0);
    check({tag, ".rst_faddr"}, bus.fault_addr, 32'd0);
    check({tag, ".rst_count"}, bus.fetch_count, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        req;
    logic        bt, j, st, rdy;
    logic [31:0] off, jt;

    // Directed table. It starts from reset release with RESET_PC = 0x100.
    vecs[0]  = mk(0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h100,      0,  0); // bubble
    vecs[1]  = mk(0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h104,      1,  0);
    vecs[2]  = mk(0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h108,      2,  0);
    vecs[3]  = mk(0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h10C,      3,  0);
    vecs[4]  = mk(0, 32'h0,        1, 32'h200,      0, 1, 1, 32'h200,      4,  0);
    vecs[5]  = mk(1, 32'hFFFFFFFD, 0, 32'h0,        0, 1, 1, 32'h1F8,      5,  0); // branch -3
    vecs[6]  = mk(0, 32'h0,        1, 32'h200,      0, 1, 1, 32'h200,      6,  0);
    vecs[7]  = mk(0, 32'hFFFFFFFD, 0, 32'h0,        0, 1, 1, 32'h204,      7,  0); // not taken
    vecs[8]  = mk(0, 32'h0,        1, 32'h40,       0, 1, 1, 32'h40,       8,  0);
    vecs[9]  = mk(1, 32'h5,        1, 32'h1000,     0, 1, 1, 32'h1000,     9,  0); // jump wins
    vecs[10] = mk(0, 32'h0,        1, 32'h20,       0, 1, 1, 32'h20,       10, 0);
    vecs[11] = mk(1, 32'h7,        0, 32'h0,        1, 1, 0, 32'h20,       10, 0); // stall
    vecs[12] = mk(1, 32'h7,        0, 32'h0,        1, 1, 0, 32'h20,       10, 0);
    vecs[13] = mk(1, 32'h7,        0, 32'h0,        1, 1, 0, 32'h20,       10, 0);
    vecs[14] = mk(1, 32'h7,        0, 32'h0,        0, 0, 1, 32'h20,       10, 0); // backpressure
    vecs[15] = mk(1, 32'h7,        0, 32'h0,        0, 0, 1, 32'h20,       10, 0);
    vecs[16] = mk(0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h24,       11, 0);
    vecs[17] = mk(0, 32'h0,        1, 32'hFFFFFFFC, 0, 1, 1, 32'hFFFFFFFC, 12, 0);
    vecs[18] = mk(0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h0,        13, 0); // pc wrap
    vecs[19] = mk(0, 32'h0,        1, 32'h1000,     0, 1, 1, 32'h1000,     14, 0);
    vecs[20] = mk(1, 32'h3,        1, 32'h1002,     0, 1, 1, 32'h1000,     15, 1); // misaligned
    vecs[21] = mk(0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h1000,     15, 1);
    vecs[22] = mk(0, 32'h0,        1, 32'h2000,     0, 1, 0, 32'h1000,     15, 1);

    // Reset state
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.pc", bus.pc, RESET_PC);
    check("reset.imem_req", 32'(bus.imem_req), 32'd0);
    check("reset.fetch_count", bus.fetch_count, 32'd0);
    check("reset.fault", 32'(bus.fault), 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 23; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_cycle(tag, vecs[i].bt, vecs[i].off, vecs[i].j, vecs[i].jt,
                vecs[i].st, vecs[i].rdy, req);
      check({tag, ".tbl_req"}, 32'(req), 32'(vecs[i].exp_req));
      check({tag, ".tbl_pc"}, bus.pc, vecs[i].exp_pc);
      check({tag, ".tbl_cnt"}, bus.fetch_count, vecs[i].exp_cnt);
      check({tag, ".tbl_fault"}, 32'(bus.fault), 32'(vecs[i].exp_fault));
    end
    check("fault.addr", bus.fault_addr, 32'h1002);

    // The fault is sticky across further traffic and clears only on reset.
    for (int i = 0; i < 3; i++) begin
      run_cycle($sformatf("sticky%0d", i), 1, 32'h2, 1, 32'h300, 0, 1, req);
      check("sticky.req", 32'(req), 32'd0);
    end
    async_reset_pulse("fault_clear");

    // fetch_count wrap: preload the counter during a stalled cycle.
    run_cycle("wrap.bubble", 0, 0, 0, 0, 0, 1, req);
    drive(0, 0, 0, 0, 1, 1);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    m_cnt = 32'hFFFF_FFFF;
    check("wrap.preload", bus.fetch_count, 32'hFFFF_FFFF);
    run_cycle("wrap.accept", 0, 0, 0, 0, 0, 1, req);
    check("wrap.count_zero", bus.fetch_count, 32'd0);

    // Asynchronous reset while a request waits on imem_ready.
    run_cycle("async.a", 0, 0, 0, 0, 0, 1, req);
    run_cycle("async.b", 0, 0, 0, 0, 0, 1, req);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("async.req_pending", 32'(bus.imem_req), 32'd1);
    check("async.pc_before", bus.pc, RESET_PC + 32'd12);
    async_reset_pulse("async");

    // Random traffic, with occasional reset pulses between clock edges.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset_pulse($sformatf("rnd%0d", n));
      end else begin
        bt  = 1'($urandom_range(0, 1));
        off = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) - 32'd32 : $urandom;
        j   = ($urandom_range(0, 4) == 0);
        jt  = $urandom;
        if ($urandom_range(0, 7) != 0) jt[1:0] = 2'b00;
        st  = ($urandom_range(0, 3) == 0);
        rdy = ($urandom_range(0, 2) != 0);
        run_cycle($sformatf("rnd%0d", n), bt, off, j, jt, st, rdy, req);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
